// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the fetch PC, issues req/gnt/rvalid fetches under a
// credit limit, buffers {pc, instr} in a prefetch FIFO and discards wrong-path returns.
module if_stage #(
  parameter logic [31:0] BOOT_ADDR  = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_if_i,
  input  logic        jump_decision_i,
  input  logic [31:0] jump_target_i,
  input  logic        branch_decision_i,
  input  logic [31:0] branch_target_i,
  output logic        instr_req_o,
  output logic [31:0] instr_addr_o,
  input  logic        instr_gnt_i,
  input  logic        instr_rvalid_i,
  input  logic [31:0] instr_rdata_i,
  output logic        instr_valid_o,
  output logic [31:0] instr_o,
  output logic [31:0] pc_if_o
);
  localparam int            AW      = $clog2(FIFO_DEPTH);
  localparam int            CW      = AW + 1;
  localparam logic [CW:0]   DEPTH_C = (CW+1)'(FIFO_DEPTH);

  typedef enum logic {RUN, DRAIN} state_t;

  state_t        r_state, w_state_nxt;
  logic [31:0]   r_fetch_pc;
  logic [CW-1:0] r_outstanding, r_drop, r_count;
  logic [CW-1:0] w_outst_nxt, w_drop_nxt;
  logic [AW-1:0] r_wptr, r_rptr, r_qw, r_qr;
  logic [31:0]   r_fifo_pc    [FIFO_DEPTH];
  logic [31:0]   r_fifo_instr [FIFO_DEPTH];
  logic [31:0]   r_pcq        [FIFO_DEPTH];

  logic          w_redirect, w_credit, w_req, w_gnt, w_valid, w_pop, w_push;
  logic [31:0]   w_target;

  assign w_redirect = branch_decision_i | jump_decision_i;
  assign w_target   = branch_decision_i ? {branch_target_i[31:2], 2'b00}
                                        : {jump_target_i[31:2], 2'b00};
  // Buffered plus in-flight entries never exceed the FIFO, so a push always has room.
  assign w_credit   = ({1'b0, r_outstanding} + {1'b0, r_count}) < DEPTH_C;
  assign w_req      = !rst && (r_state == RUN) && !w_redirect && w_credit;
  assign w_gnt      = w_req && instr_gnt_i;
  assign w_valid    = !rst && (r_count != '0) && !w_redirect;
  assign w_pop      = w_valid && !stall_if_i;
  assign w_push     = instr_rvalid_i && !w_redirect && (r_drop == '0);
  assign w_outst_nxt = r_outstanding + CW'(w_gnt) - CW'(instr_rvalid_i);

  assign instr_req_o   = w_req;
  assign instr_addr_o  = rst ? BOOT_ADDR : r_fetch_pc;
  assign instr_valid_o = w_valid;
  assign instr_o       = rst ? 32'h0 : r_fifo_instr[r_rptr];
  assign pc_if_o       = rst ? 32'h0 : r_fifo_pc[r_rptr];

  always_comb begin
    w_state_nxt = r_state;
    w_drop_nxt  = r_drop;
    if (w_redirect) begin
      // Everything still in flight after this cycle belongs to the old path.
      w_drop_nxt  = w_outst_nxt;
      w_state_nxt = (w_outst_nxt != '0) ? DRAIN : RUN;
    end else if (instr_rvalid_i && (r_drop != '0)) begin
      w_drop_nxt = r_drop - CW'(1);
      if (r_drop == CW'(1)) w_state_nxt = RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= RUN;
      r_fetch_pc    <= BOOT_ADDR;
      r_outstanding <= '0;
      r_drop        <= '0;
      r_qw          <= '0;
      r_qr          <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_drop        <= w_drop_nxt;
      r_outstanding <= w_outst_nxt;
      if (w_redirect)  r_fetch_pc <= w_target;
      else if (w_gnt)  r_fetch_pc <= r_fetch_pc + 32'd4;
      if (w_gnt) begin
        r_pcq[r_qw] <= r_fetch_pc;
        r_qw        <= r_qw + AW'(1);
      end
      if (instr_rvalid_i) r_qr <= r_qr + AW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst || (!rst && w_redirect)) begin
      r_count <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
    end else begin
      if (w_push) begin
        r_fifo_pc[r_wptr]    <= r_pcq[r_qr];
        r_fifo_instr[r_wptr] <= instr_rdata_i;
        r_wptr               <= r_wptr + AW'(1);
      end
      if (w_pop) r_rptr <= r_rptr + AW'(1);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end
endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: in-order memory model plus a request-level scoreboard that tracks
// granted/stale fetches, buffered entries and the expected architectural PC stream.
module tb_if_stage;
  localparam int          DEPTH = 2;
  localparam logic [31:0] BOOT  = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst, stall_if_i, jump_decision_i, branch_decision_i;
  logic [31:0] jump_target_i, branch_target_i;
  logic        instr_req_o, instr_gnt_i, instr_rvalid_i, instr_valid_o;
  logic [31:0] instr_addr_o, instr_rdata_i, instr_o, pc_if_o;

  if_stage #(.BOOT_ADDR(BOOT), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .stall_if_i(stall_if_i),
    .jump_decision_i(jump_decision_i), .jump_target_i(jump_target_i),
    .branch_decision_i(branch_decision_i), .branch_target_i(branch_target_i),
    .instr_req_o(instr_req_o), .instr_addr_o(instr_addr_o), .instr_gnt_i(instr_gnt_i),
    .instr_rvalid_i(instr_rvalid_i), .instr_rdata_i(instr_rdata_i),
    .instr_valid_o(instr_valid_o), .instr_o(instr_o), .pc_if_o(pc_if_o));

  always #5 clk = ~clk;

  int          errs = 0, checks = 0, cyc = 0;
  logic [31:0] q_addr[$];
  bit          q_stale[$];
  int          buf_n = 0;
  logic [31:0] exp_pc = BOOT, exp_fetch = BOOT;
  bit          g_req, g_gnt, g_valid;
  logic [31:0] g_addr, g_pc;

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000;
  endfunction

  // One clock cycle: entered at posedge+1, drives inputs, checks at negedge, updates model.
  task automatic cycle(input bit rs, input bit bd, input logic [31:0] bt, input bit jd,
                       input logic [31:0] jt, input bit st, input bit ge, input bit re);
    bit drain, redir, e_req, e_val, popped, pop_stale;
    int qs, bs;
    logic [31:0] tgt, want_addr;
    drain = 0;
    foreach (q_stale[i]) if (q_stale[i]) drain = 1;
    qs = q_addr.size(); bs = buf_n;
    redir = bd | jd;
    e_req = !rs && !redir && !drain && ((qs + bs) < DEPTH);
    e_val = !rs && !redir && (bs > 0);
    rst = rs; branch_decision_i = bd; branch_target_i = bt;
    jump_decision_i = jd; jump_target_i = jt; stall_if_i = st;
    instr_gnt_i = ge && e_req;
    popped = 0; pop_stale = 0;
    if (re && qs > 0 && !rs) begin
      instr_rvalid_i = 1'b1;
      instr_rdata_i  = mem_data(q_addr[0]);
      pop_stale      = q_stale[0];
      void'(q_addr.pop_front()); void'(q_stale.pop_front());
      popped = 1;
    end else begin
      instr_rvalid_i = 1'b0;
      instr_rdata_i  = $urandom;
    end
    @(negedge clk);
    want_addr = rs ? BOOT : exp_fetch;
    checks++;
    if (instr_req_o !== e_req) begin
      errs++; $display("FAIL req cyc=%0d got=%b want=%b", cyc, instr_req_o, e_req);
    end
    checks++;
    if (instr_addr_o !== want_addr) begin
      errs++; $display("FAIL addr cyc=%0d got=%h want=%h", cyc, instr_addr_o, want_addr);
    end
    checks++;
    if (instr_valid_o !== e_val) begin
      errs++; $display("FAIL valid cyc=%0d got=%b want=%b", cyc, instr_valid_o, e_val);
    end
    if (e_val) begin
      checks++;
      if (pc_if_o !== exp_pc || instr_o !== mem_data(exp_pc)) begin
        errs++; $display("FAIL head cyc=%0d pc=%h instr=%h want pc=%h instr=%h",
                         cyc, pc_if_o, instr_o, exp_pc, mem_data(exp_pc));
      end
    end
    if (rs) begin
      checks++;
      if (instr_o !== 32'h0 || pc_if_o !== 32'h0) begin
        errs++; $display("FAIL rst_out cyc=%0d instr=%h pc=%h want 0", cyc, instr_o, pc_if_o);
      end
    end
    g_req = instr_req_o; g_addr = instr_addr_o; g_gnt = instr_gnt_i;
    g_valid = instr_valid_o; g_pc = pc_if_o;
    if (rs) begin
      q_addr.delete(); q_stale.delete(); buf_n = 0; exp_fetch = BOOT; exp_pc = BOOT;
    end else begin
      if (e_val && !st) begin buf_n--; exp_pc += 32'd4; end
      if (instr_gnt_i) begin q_addr.push_back(exp_fetch); q_stale.push_back(0); exp_fetch += 32'd4; end
      if (redir) begin
        tgt = bd ? bt : jt; tgt[1:0] = 2'b00;
        exp_fetch = tgt; exp_pc = tgt; buf_n = 0;
        foreach (q_stale[i]) q_stale[i] = 1;
      end else if (popped && !pop_stale) buf_n++;
    end
    @(posedge clk); #1;
    cyc++;
  endtask

  task automatic run(input bit st, input bit ge, input bit re);
    cycle(0, 0, 32'h0, 0, 32'h0, st, ge, re);
  endtask

  task automatic timeout(input string name);
    checks++; errs++; $display("FAIL timeout %s cyc=%0d", name, cyc);
  endtask

  task automatic test_reset;
    cycle(1, 0, 0, 0, 0, 0, 1, 1);
    cycle(1, 0, 0, 0, 0, 0, 1, 1);
    checks++;
    if (g_req !== 0 || g_valid !== 0 || g_addr !== BOOT) begin
      errs++; $display("FAIL reset_state req=%b valid=%b addr=%h want 0 0 %h", g_req, g_valid, g_addr, BOOT);
    end
  endtask

  task automatic test_fetch;
    int first_v = -1;
    logic [31:0] nxt = BOOT;
    cycle(1, 0, 0, 0, 0, 0, 1, 1);
    for (int i = 0; i < 20; i++) begin
      run(0, 1, 1);
      if (i == 0) begin
        checks++;
        if (g_req !== 1 || g_addr !== BOOT) begin
          errs++; $display("FAIL first_req req=%b addr=%h want 1 %h", g_req, g_addr, BOOT);
        end
      end
      if (g_valid) begin
        if (first_v < 0) first_v = i;
        checks++;
        if (g_pc !== nxt) begin errs++; $display("FAIL seq pc=%h want=%h", g_pc, nxt); end
        nxt += 32'd4;
      end
    end
    checks++;
    if (first_v != 2) begin errs++; $display("FAIL first_valid cycle=%0d want=2", first_v); end
  endtask

  task automatic test_stall;
    int k = 0;
    cycle(1, 0, 0, 0, 0, 0, 1, 1);
    while (!(exp_pc == 32'h8 && buf_n > 0) && k < 30) begin run(0, 1, 1); k++; end
    if (k >= 30) timeout("stall_setup");
    for (int i = 0; i < 5; i++) begin
      run(1, 1, 1);
      checks++;
      if (g_valid !== 1 || g_pc !== 32'h8) begin
        errs++; $display("FAIL stall_hold i=%0d valid=%b pc=%h want 1 8", i, g_valid, g_pc);
      end
    end
    checks++;
    if (g_req !== 0) begin errs++; $display("FAIL stall_noreq req=%b want 0", g_req); end
    run(0, 1, 1);
    run(0, 1, 1);
    checks++;
    if (g_valid !== 1 || g_pc !== 32'hC) begin
      errs++; $display("FAIL stall_release valid=%b pc=%h want 1 c", g_valid, g_pc);
    end
  endtask

  task automatic test_jump;
    int k = 0, first_req = -1, bad = 0;
    bit got_v = 0;
    logic [31:0] req_addr = 0, v_pc = 0;
    cycle(1, 0, 0, 0, 0, 0, 1, 1);
    while (exp_fetch != 32'h10 && k < 30) begin run(0, 1, 1); k++; end
    while (q_addr.size() != 0 && k < 60) begin run(0, 0, 1); k++; end
    while (q_addr.size() != 2 && k < 90) begin run(0, 1, 0); k++; end
    if (k >= 90) timeout("jump_setup");
    cycle(0, 0, 0, 1, 32'h103, 0, 1, 0);
    for (int i = 0; i < 12; i++) begin
      run(0, 1, 1);
      if (g_req && first_req < 0) begin first_req = i; req_addr = g_addr; end
      if (g_valid && !got_v) begin got_v = 1; v_pc = g_pc; end
      if (g_valid && (g_pc == 32'h10 || g_pc == 32'h14)) bad++;
    end
    checks++;
    if (first_req != 2 || req_addr !== 32'h100) begin
      errs++; $display("FAIL jump_req idx=%0d addr=%h want 2 100", first_req, req_addr);
    end
    checks++;
    if (!got_v || v_pc !== 32'h100) begin errs++; $display("FAIL jump_first pc=%h want 100", v_pc); end
    checks++;
    if (bad != 0) begin errs++; $display("FAIL jump_stale count=%0d want 0", bad); end
  endtask

  task automatic test_priority;
    int k = 0;
    cycle(0, 1, 32'h200, 1, 32'h300, 0, 1, 1);
    while (!g_gnt && k < 10) begin run(0, 1, 1); k++; end
    if (k >= 10) timeout("prio_req");
    else begin
      checks++;
      if (g_addr !== 32'h200) begin errs++; $display("FAIL prio_addr got=%h want=200", g_addr); end
    end
    k = 0;
    while (!g_valid && k < 10) begin run(0, 1, 1); k++; end
    if (k >= 10) timeout("prio_valid");
    else begin
      checks++;
      if (g_pc !== 32'h200) begin errs++; $display("FAIL prio_pc got=%h want=200", g_pc); end
    end
  endtask

  task automatic test_gnt_hold;
    int k = 0;
    cycle(0, 0, 0, 1, 32'h40, 0, 0, 1);
    while (!g_req && k < 10) begin run(0, 0, 1); k++; end
    if (k >= 10) timeout("hold_req");
    for (int i = 0; i < 3; i++) begin
      run(0, 0, 1);
      checks++;
      if (g_req !== 1 || g_addr !== 32'h40) begin
        errs++; $display("FAIL hold i=%0d req=%b addr=%h want 1 40", i, g_req, g_addr);
      end
    end
    cycle(0, 0, 0, 1, 32'h80, 0, 0, 1);
    checks++;
    if (g_req !== 0) begin errs++; $display("FAIL abort req=%b want 0", g_req); end
    k = 0;
    while (!g_gnt && k < 10) begin run(0, 1, 1); k++; end
    if (k >= 10) timeout("abort_gnt");
    else begin
      checks++;
      if (g_addr !== 32'h80) begin errs++; $display("FAIL abort_addr got=%h want=80", g_addr); end
    end
  endtask

  task automatic test_wrap;
    int k = 0;
    cycle(0, 0, 0, 1, 32'hFFFF_FFFC, 0, 0, 1);
    while (!g_gnt && k < 10) begin run(0, 1, 1); k++; end
    checks++;
    if (!g_gnt || g_addr !== 32'hFFFF_FFFC) begin
      errs++; $display("FAIL wrap_first gnt=%b addr=%h want 1 fffffffc", g_gnt, g_addr);
    end
    k = 0;
    run(0, 1, 1);
    while (!g_gnt && k < 10) begin run(0, 1, 1); k++; end
    checks++;
    if (!g_gnt || g_addr !== 32'h0) begin
      errs++; $display("FAIL wrap_next gnt=%b addr=%h want 1 0", g_gnt, g_addr);
    end
    for (int i = 0; i < 6; i++) run(0, 1, 1);
  endtask

  task automatic test_reset_mid;
    int k = 0;
    while (buf_n != DEPTH && k < 20) begin run(1, 1, 1); k++; end
    if (k >= 20) timeout("full_setup");
    cycle(1, 0, 0, 0, 0, 1, 1, 1);
    cycle(1, 0, 0, 0, 0, 1, 1, 1);
    checks++;
    if (g_req !== 0 || g_valid !== 0) begin
      errs++; $display("FAIL rst_mid req=%b valid=%b want 0 0", g_req, g_valid);
    end
    run(0, 1, 1);
    checks++;
    if (g_req !== 1 || g_addr !== BOOT) begin
      errs++; $display("FAIL rst_restart req=%b addr=%h want 1 %h", g_req, g_addr, BOOT);
    end
  endtask

  task automatic test_random;
    for (int i = 0; i < 600; i++) begin
      cycle($urandom_range(0, 149) == 0, $urandom_range(0, 19) == 0, $urandom,
            $urandom_range(0, 11) == 0, $urandom, $urandom_range(0, 2) == 0,
            $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0);
    end
  endtask

  initial begin
    rst = 1; stall_if_i = 0; jump_decision_i = 0; branch_decision_i = 0;
    jump_target_i = 0; branch_target_i = 0; instr_gnt_i = 0; instr_rvalid_i = 0; instr_rdata_i = 0;
    @(posedge clk); #1;
    test_reset;
    test_fetch;
    test_stall;
    test_jump;
    test_priority;
    test_gnt_hold;
    test_wrap;
    test_reset_mid;
    test_random;
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
